// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state encoding and opcode constants for the instruction
//            fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Sequencer states, one per phase of the fetch/issue handshake
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    IMM    = 3'd4,
    WAIT   = 3'd5,
    HALT   = 3'd6
  } state_t;

  // Opcode field lives in bits [15:13] of the instruction word
  localparam int          OPC_MSB = 15;
  localparam int          OPC_LSB = 13;

  localparam logic [2:0]  OP_MV   = 3'b000;
  localparam logic [2:0]  OP_MVI  = 3'b001;
  localparam logic [2:0]  OP_ADD  = 3'b010;
  localparam logic [2:0]  OP_SUB  = 3'b011;
  localparam logic [2:0]  OP_HALT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter
// Purpose  : Program counter with async clear to the start address, a
//            synchronous reload of the start address and wrapping increment.
// Revision : 1.0 - initial release
// ============================================================================
module pc_counter #(
  parameter int ADDR_W     = 5,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: reload wins over increment; increment wraps naturally
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = START_PC;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register, cleared to the start address asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= START_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prog_sequencer
// Purpose  : Instruction fetch stage feeding a 16-bit processor. Reads words
//            from a synchronous ROM, issues them on DIN with Run, supplies the
//            MVI immediate one cycle later, waits for Done, stops on HALT.
// Revision : 1.0 - initial release
// ============================================================================
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int START_ADDR = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  input  logic [DATA_W-1:0] Mem_data,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Halted,
  output logic [ADDR_W-1:0] Pc,
  output logic [15:0]       Instr_count
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        mem_op;
  logic [2:0]        din_op;

  assign mem_op = Mem_data[OPC_MSB:OPC_LSB];
  assign din_op = din_q[OPC_MSB:OPC_LSB];

  pc_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc (
    .clk   (Clock),
    .rst_n (Resetn),
    .load  (pc_load),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // Next-state, DIN register, PC control and issued-instruction counter
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        // ROM word for PC is valid now; the halt word itself is never issued
        din_d   = Mem_data;
        pc_inc  = 1'b1;
        state_d = (mem_op == OP_HALT) ? HALT : ISSUE;
      end
      ISSUE: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        state_d = (din_op == OP_MVI) ? IMM : WAIT;
      end
      IMM: begin
        din_d   = Mem_data;
        pc_inc  = 1'b1;
        state_d = Done ? FETCH : WAIT;
      end
      WAIT: begin
        if (Done) begin
          state_d = FETCH;
        end
      end
      HALT: begin
        if (Start) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, DIN and counter registers with asynchronous clear
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  // The immediate bypasses the register so it reaches the processor in T1
  assign DIN         = (state_q == IMM) ? Mem_data : din_q;
  assign Run         = (state_q == ISSUE) || (state_q == IMM) || (state_q == WAIT);
  assign Halted      = (state_q == HALT);
  assign Mem_addr    = pc;
  assign Pc          = pc;
  assign Instr_count = cnt_q;

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
# prog_sequencer

Instruction-fetch stage placed directly upstream of the simple 16-bit processor. It walks a program counter through a synchronous instruction ROM and presents each instruction word on the processor's `DIN` with `Run` asserted. For `mvi`, it supplies the immediate word on the following cycle. It then waits for the processor's `Done` before fetching the next instruction, and stops on a halt opcode.

## Interface
- `ADDR_W`, default 5: ROM address width; PC width.
- `DATA_W`, default 16: instruction/data word width.
- `START_ADDR`, default 0: PC value loaded on reset and on every accepted `Start`.

Ports:
- `Clock`, input, 1: the only clock; all state updates on the rising edge.
- `Resetn`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: begin execution at `START_ADDR`; sampled only in IDLE or HALT.
- `Done`, input, 1: instruction-complete pulse from the processor.
- `Mem_data`, input, `DATA_W`: ROM read data, valid the cycle after `Mem_addr`.
- `Mem_addr`, output, `ADDR_W`: ROM address (combinational from state/PC).
- `DIN`, output, `DATA_W`: word driven to the processor.
- `Run`, output, 1: instruction in flight.
- `Halted`, output, 1: halt opcode reached.
- `Pc`, output, `ADDR_W`: current PC.
- `Instr_count`, output, 16: number of instructions issued; saturates at 16'hFFFF.

## Operation
- Opcode is `DIN[15:13]`. Values: MV=000, MVI=001, ADD=010, SUB=011, HALT=111. All other opcodes issue as single-word instructions.
- States and transitions:
  - IDLE: `Run`=0, `Mem_addr`=PC. On `Start`, PC←`START_ADDR`, go to FETCH.
  - FETCH: `Mem_addr`=PC; go to DECODE.
  - DECODE: `Mem_data` is valid. Latch it into the `DIN` register; PC←PC+1.
    - If opcode is HALT, go to HALT. The halt word is not issued.
    - Otherwise go to ISSUE.
  - ISSUE: `Run`=1 (processor T0). `Instr_count`+1. `Done` is ignored in this state.
    - If MVI: `Mem_addr`=PC, go to IMM.
    - Otherwise go to WAIT.
  - IMM: `Run`=1. `DIN` is driven directly from `Mem_data` (the immediate, processor T1). Latch the immediate into the `DIN` register; PC←PC+1.
    - If `Done`=1, go to FETCH.
    - Otherwise go to WAIT.
  - WAIT: `Run`=1, `DIN` held. If `Done`=1, go to FETCH.
  - HALT: `Halted`=1, `Run`=0. On `Start`: `Halted`←0, PC←`START_ADDR`, go to FETCH.
- PC wraps from 2^`ADDR_W`-1 to 0, including an MVI whose immediate sits at address 0 after the wrap.
- `Start` in FETCH, DECODE, ISSUE, IMM or WAIT is ignored.
- `Done` in IDLE, FETCH, DECODE or HALT is ignored.
- `Instr_count` clears only on reset.

## Timing
- Reset values: state=IDLE, PC=`START_ADDR`, `DIN`=0, `Run`=0, `Halted`=0, `Instr_count`=0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Latency from `Start` to first `Run`: 3 cycles (FETCH, DECODE, ISSUE).
- Single-word instruction: `Run` rises in ISSUE and falls the cycle after `Done` is sampled.
- Latency from `Done` to next `Run`: 3 cycles.
- MVI: the instruction word is on `DIN` in ISSUE, and the immediate is on `DIN` exactly one cycle later.
- Throughput minimum is 4 cycles per single-word instruction.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum (IDLE, FETCH, DECODE, ISSUE, IMM, WAIT, HALT);
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_HALT`.
- One sub-module, `pc_counter`: `ADDR_W`-bit register with async clear to `START_ADDR`, a synchronous load of `START_ADDR`, and increment with wrap.
- FSM, `DIN` mux/register and the saturating counter live in the top level.

## Test plan
- Reset mid-WAIT, with `Run`=1 → `Run`, `Halted`, `DIN` and `Instr_count` read 0 and `Pc`=0 before the next edge.
- ROM {0:16'h2000, 1:16'h0005, 2:16'hE000}, `Start` pulse:
  - → `DIN`=16'h2000 with `Run`=1 at cycle 3;
  - → `DIN`=16'h0005 at cycle 4;
  - `Done` returned in cycle 4 → `Halted`=1, `Instr_count`=1, `Pc`=3.
- ROM {0:16'h0400, 1:16'hE000}, `Done` delayed 5 cycles after ISSUE → `Run` held 6 cycles, `DIN`=16'h0400 stable throughout, then `Halted`=1.
- `START_ADDR`=31, ROM {31:16'h2000, 0:16'h00AA, 1:16'hE000} → immediate 16'h00AA issued (PC wraps), halt at `Pc`=2.
- `Start` pulsed during WAIT → ignored. `Start` pulsed in HALT → `Halted`=0 next cycle and the program re-runs from `START_ADDR`.
- `Done` forced high during DECODE/ISSUE → no state advance beyond the normal sequence.
